universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//   WIDTH-bit universal shift register: hold, shift right, shift left or parallel load.
//   The 2-bit mode select picks one operation per rising clock edge.
//   General-purpose datapath primitive for serial/parallel conversion and bit-stream alignment.
//   All state lives in one WIDTH-bit register that drives 'out' directly.
// PARAMETERS
//   WIDTH  4  register width in bits (>=2)
// PORTS
//   clk              in   1      single clock; all state updates on rising edge
//   reset            in   1      synchronous, active-high reset, sampled on rising clk edge
//   ctrl             in   2      mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   serial_in_right  in   1      bit inserted at LSB (out[0]) on shift left
//   serial_in_left   in   1      bit inserted at MSB (out[WIDTH-1]) on shift right
//   parallel_in      in   WIDTH  data loaded in mode 11
//   out              out  WIDTH  registered register contents
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high (ports clk, reset).
//   - reset=1 at a rising edge: out <= 0, regardless of ctrl and data inputs.
//   - Reset has priority over every mode and wins mid-sequence.
//   - reset=0, per rising edge:
//       00 hold : out <= out
//       01 right: out <= {serial_in_left, out[WIDTH-1:1]}  (out[0] discarded)
//       10 left : out <= {out[WIDTH-2:0], serial_in_right} (out[WIDTH-1] discarded)
//       11 load : out <= parallel_in
//   - Latency: one cycle; the new value appears after the edge that samples ctrl/data.
//   - No combinational path from any input to out.
//   - Serial inputs are ignored outside their own shift mode.
//   - parallel_in is ignored except in mode 11.
//   - ctrl is fully decoded; there are no illegal codes.
//   - Back-to-back shifts are unlimited; after WIDTH shifts the register holds only serial-input bits.
//   - No X-propagation special handling is required; inputs are assumed driven.
// CONFIGURATION
//   USR_SERIAL_OUT_EN defined:
//     - adds output serial_out_right (1) = out[0]: bit shifted out on shift right.
//     - adds output serial_out_left  (1) = out[WIDTH-1]: bit shifted out on shift left.
//     - both outputs are combinational copies of register bits; both reset to 0 with the register.
//   USR_SERIAL_OUT_EN undefined:
//     - these ports and their logic are absent.
//     - the core behaviour above is unchanged.
// TESTING
//   (WIDTH=4, clk period 10 ns, inputs change away from the rising edge)
//   1 reset=1 for one edge, ctrl=00 -> out=0000; release reset, ctrl=00 -> out stays 0000.
//   2 parallel_in=1010, ctrl=11 -> out=1010; then ctrl=00 for one edge -> out=1010.
//   3 from 1010: ctrl=01, serial_in_left=1 -> 1101; next edge serial_in_left=0 -> 0110.
//   4 from 0110: ctrl=10, serial_in_right=1 -> 1101; next edge serial_in_right=0 -> 1010.
//   5 ctrl=11, parallel_in=1100 -> 1100; ctrl=00 -> holds 1100.
//     Then reset=1 with ctrl=11, parallel_in=1111 -> 0000 (reset wins).
//   6 USR_SERIAL_OUT_EN: out=1010 -> serial_out_right=0, serial_out_left=1.
//     One shift right with serial_in_left=0 -> out=0101, serial_out_right=1.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// selected by a 2-bit mode per rising clock edge. Synchronous active-high reset.
// Optional serial taps of the end bits are enabled by defining USR_SERIAL_OUT_EN.
module universal_shift_register #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ctrl,
  input  logic             serial_in_right,
  input  logic             serial_in_left,
  input  logic [WIDTH-1:0] parallel_in,
`ifdef USR_SERIAL_OUT_EN
  output logic             serial_out_right,
  output logic             serial_out_left,
`endif
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  mode_t            mode;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  assign mode = mode_t'(ctrl);

  // Next register value for the selected mode
  always_comb begin
    out_d = out_q;
    case (mode)
      MODE_HOLD:  out_d = out_q;
      MODE_RIGHT: out_d = {serial_in_left, out_q[WIDTH-1:1]};
      MODE_LEFT:  out_d = {out_q[WIDTH-2:0], serial_in_right};
      MODE_LOAD:  out_d = parallel_in;
      default:    out_d = out_q;
    endcase
  end

  // State register; reset overrides every mode
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

`ifdef USR_SERIAL_OUT_EN
  assign serial_out_right = out_q[0];
  assign serial_out_left  = out_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=4): directed steps
// followed by randomized steps compared against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int unsigned W    = 4;
  localparam int unsigned MOD  = 1 << W;
  localparam int unsigned TOPV = 1 << (W - 1);

  logic         clk;
  logic         reset;
  logic [1:0]   ctrl;
  logic         serial_in_right;
  logic         serial_in_left;
  logic [W-1:0] parallel_in;
  logic [W-1:0] out;
`ifdef USR_SERIAL_OUT_EN
  logic         serial_out_right;
  logic         serial_out_left;
`endif

  int unsigned tests_run;
  int unsigned tests_failed;
  int unsigned model;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .ctrl            (ctrl),
    .serial_in_right (serial_in_right),
    .serial_in_left  (serial_in_left),
    .parallel_in     (parallel_in),
`ifdef USR_SERIAL_OUT_EN
    .serial_out_right(serial_out_right),
    .serial_out_left (serial_out_left),
`endif
    .out             (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: register contents as an integer in [0, 2^W)
  function automatic int unsigned ref_next(input int unsigned v, input logic r,
                                           input logic [1:0] c, input logic sil,
                                           input logic sir, input logic [W-1:0] p);
    if (r) return 0;
    case (c)
      2'd0:    return v;
      2'd1:    return (v / 2) + (sil ? TOPV : 0);
      2'd2:    return ((v * 2) % MOD) + (sir ? 1 : 0);
      default: return int'(p);
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] exp);
    tests_run++;
    assert (out === exp) else begin
      tests_failed++;
      $error("FAIL %s: out=%b expected=%b", tag, out, exp);
    end
`ifdef USR_SERIAL_OUT_EN
    tests_run++;
    assert (serial_out_right === exp[0] && serial_out_left === exp[W-1]) else begin
      tests_failed++;
      $error("FAIL %s_sout: right=%b left=%b expected right=%b left=%b",
             tag, serial_out_right, serial_out_left, exp[0], exp[W-1]);
    end
`endif
  endtask

  // Drive one edge worth of inputs, advance the model, check after the edge
  task automatic step(input string tag, input logic r, input logic [1:0] c,
                      input logic sil, input logic sir, input logic [W-1:0] p);
    reset           = r;
    ctrl            = c;
    serial_in_left  = sil;
    serial_in_right = sir;
    parallel_in     = p;
    model = ref_next(model, r, c, sil, sir, p);
    @(posedge clk);
    #1;
    check_val(tag, model[W-1:0]);
  endtask

  initial begin
    logic [W-1:0] k;
    tests_run       = 0;
    tests_failed    = 0;
    model           = 0;
    reset           = 1'b1;
    ctrl            = 2'b00;
    serial_in_left  = 1'b0;
    serial_in_right = 1'b0;
    parallel_in     = '0;
    #2;

    // Reset, then hold after release
    step("reset",      1'b1, 2'b00, 1'b0, 1'b0, 4'b0000); k = 4'b0000; check_val("reset_lit", k);
    step("rel_hold",   1'b0, 2'b00, 1'b1, 1'b1, 4'b1111); k = 4'b0000; check_val("rel_hold_lit", k);
    // Load and hold
    step("load_1010",  1'b0, 2'b11, 1'b1, 1'b1, 4'b1010); k = 4'b1010; check_val("load_lit", k);
    step("hold_1010",  1'b0, 2'b00, 1'b1, 1'b1, 4'b0101); k = 4'b1010; check_val("hold_lit", k);
    // Shift right twice, serial_in_right and parallel_in must be ignored
    step("sr_1",       1'b0, 2'b01, 1'b1, 1'b0, 4'b1111); k = 4'b1101; check_val("sr_1_lit", k);
    step("sr_0",       1'b0, 2'b01, 1'b0, 1'b1, 4'b1111); k = 4'b0110; check_val("sr_0_lit", k);
    // Shift left twice, serial_in_left ignored
    step("sl_1",       1'b0, 2'b10, 1'b0, 1'b1, 4'b0000); k = 4'b1101; check_val("sl_1_lit", k);
    step("sl_0",       1'b0, 2'b10, 1'b1, 1'b0, 4'b0000); k = 4'b1010; check_val("sl_0_lit", k);
    // Load/hold, then reset beats a concurrent load
    step("load_1100",  1'b0, 2'b11, 1'b0, 1'b0, 4'b1100); k = 4'b1100; check_val("load2_lit", k);
    step("hold_1100",  1'b0, 2'b00, 1'b0, 1'b0, 4'b0011); k = 4'b1100; check_val("hold2_lit", k);
    step("rst_wins",   1'b1, 2'b11, 1'b1, 1'b1, 4'b1111); k = 4'b0000; check_val("rst_wins_lit", k);
    // Serial-out taps and a right shift out of 1010
    step("load_1010b", 1'b0, 2'b11, 1'b0, 1'b0, 4'b1010); k = 4'b1010; check_val("load3_lit", k);
    step("sr_to_0101", 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000); k = 4'b0101; check_val("sr3_lit", k);
    // WIDTH consecutive left shifts leave only serial-in bits
    step("fill_l0",    1'b0, 2'b10, 1'b0, 1'b1, 4'b0000);
    step("fill_l1",    1'b0, 2'b10, 1'b0, 1'b1, 4'b0000);
    step("fill_l2",    1'b0, 2'b10, 1'b0, 1'b0, 4'b0000);
    step("fill_l3",    1'b0, 2'b10, 1'b0, 1'b1, 4'b0000); k = 4'b1101; check_val("fill_lit", k);

    // Randomized steps with occasional reset
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           W'($urandom_range(0, MOD - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
